// File: rtl/vc_wrr_scheduler_if.sv
// VC-side read handshake and D-side write bus shared by the scheduler and
// its surrounding FIFOs. The scheduler takes the master modport.
interface vc_wrr_scheduler_if #(
    parameter int BW = 6
);
    logic          VC0_empty;
    logic          VC1_empty;
    logic [BW-1:0] VC0_data_out;
    logic [BW-1:0] VC1_data_out;
    logic          VC0_rd;
    logic          VC1_rd;
    logic          D0_almost_full;
    logic          D1_almost_full;
    logic          D0_wr;
    logic          D1_wr;
    logic [BW-1:0] D_data_in;

    modport master (
        input  VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
        input  D0_almost_full, D1_almost_full,
        output VC0_rd, VC1_rd, D0_wr, D1_wr, D_data_in
    );

    modport slave (
        output VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
        output D0_almost_full, D1_almost_full,
        input  VC0_rd, VC1_rd, D0_wr, D1_wr, D_data_in
    );
endinterface

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler from the VC0/VC1 FIFOs to the D0/D1 FIFOs.
// One word per cycle is popped from the granted VC; the word arrives one
// cycle later and is steered to D0 or D1 by its destination bit.
module vc_wrr_scheduler #(
    parameter int BW = 6,
    parameter int WW = 4,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [WW-1:0]       Peso_VC0,
    input  logic [WW-1:0]       Peso_VC1,
    vc_wrr_scheduler_if.master  bus,
    output logic                idle_out,
    output logic                active_out,
    output logic                pause_out,
    output logic [CW-1:0]       cnt_VC0,
    output logic [CW-1:0]       cnt_VC1
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2,
        S_PAUSE  = 2'd3
    } state_t;

    // A zero weight would starve its VC, so it is clamped up to one word.
    function automatic logic [WW-1:0] clamp_weight(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    state_t        state_q, state_d;
    logic          cur_vc_q, cur_vc_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [WW-1:0] w0_q, w0_d;
    logic [WW-1:0] w1_q, w1_d;
    logic          vld_p1_q;
    logic          vc_p1_q;
    logic [CW-1:0] cnt0_q, cnt1_q;

    logic          stall;
    logic          cur_ne, oth_ne, any_ne;
    logic [WW-1:0] w_cur, w_oth;
    logic [WW-1:0] credit_use;
    logic          grant;
    logic          grant_vc;

    assign stall  = bus.D0_almost_full | bus.D1_almost_full;
    assign cur_ne = cur_vc_q ? ~bus.VC1_empty : ~bus.VC0_empty;
    assign oth_ne = cur_vc_q ? ~bus.VC0_empty : ~bus.VC1_empty;
    assign any_ne = ~bus.VC0_empty | ~bus.VC1_empty;
    assign w_cur  = cur_vc_q ? w1_q : w0_q;
    assign w_oth  = cur_vc_q ? w0_q : w1_q;

    // Grant selection, credit bookkeeping and next-state decode.
    always_comb begin
        state_d    = state_q;
        cur_vc_d   = cur_vc_q;
        credit_d   = credit_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        credit_use = credit_q;
        grant      = 1'b0;
        grant_vc   = 1'b0;

        if (state_q != S_INIT && !init && !stall) begin
            if (cur_ne && (credit_q != '0 || !oth_ne)) begin
                // Stay on the current VC; an exhausted turn with nobody else
                // waiting restarts from this VC's own weight.
                grant      = 1'b1;
                grant_vc   = cur_vc_q;
                credit_use = (credit_q != '0) ? credit_q : w_cur;
                if (credit_use == WW'(1)) begin
                    cur_vc_d = ~cur_vc_q;
                    credit_d = w_oth;
                end else begin
                    credit_d = credit_use - WW'(1);
                end
            end else if (oth_ne) begin
                // Hand the turn over; this grant consumes one word of it.
                grant    = 1'b1;
                grant_vc = ~cur_vc_q;
                cur_vc_d = ~cur_vc_q;
                credit_d = w_oth - WW'(1);
            end
        end

        case (state_q)
            S_INIT: begin
                w0_d     = clamp_weight(Peso_VC0);
                w1_d     = clamp_weight(Peso_VC1);
                cur_vc_d = 1'b0;
                credit_d = clamp_weight(Peso_VC0);
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                if (any_ne) state_d = stall ? S_PAUSE : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (stall)        state_d = S_PAUSE;
                else if (!any_ne) state_d = S_IDLE;
            end
            S_PAUSE: begin
                if (!stall) state_d = any_ne ? S_ACTIVE : S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        if (init) state_d = S_INIT;
    end

    // Control state: FSM, turn owner, credit and latched weights.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q  <= S_INIT;
            cur_vc_q <= 1'b0;
            credit_q <= '0;
            w0_q     <= WW'(1);
            w1_q     <= WW'(1);
        end else begin
            state_q  <= state_d;
            cur_vc_q <= cur_vc_d;
            credit_q <= credit_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
        end
    end

    // Stage p0 -> p1: remember which VC was popped so its read data can be
    // forwarded when the FIFO presents it next cycle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            vld_p1_q <= 1'b0;
            vc_p1_q  <= 1'b0;
        end else begin
            vld_p1_q <= grant;
            vc_p1_q  <= grant_vc;
        end
    end

    // Per-VC grant counters, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (bus.VC0_rd) cnt0_q <= cnt0_q + CW'(1);
            if (bus.VC1_rd) cnt1_q <= cnt1_q + CW'(1);
        end
    end

    assign bus.VC0_rd    = grant & ~grant_vc;
    assign bus.VC1_rd    = grant &  grant_vc;
    assign bus.D_data_in = vld_p1_q ? (vc_p1_q ? bus.VC1_data_out : bus.VC0_data_out) : '0;
    assign bus.D0_wr     = vld_p1_q & ~bus.D_data_in[BW-2];
    assign bus.D1_wr     = vld_p1_q &  bus.D_data_in[BW-2];

    assign idle_out   = (state_q == S_IDLE);
    assign active_out = (state_q == S_ACTIVE);
    assign pause_out  = (state_q == S_PAUSE);
    assign cnt_VC0    = cnt0_q;
    assign cnt_VC1    = cnt1_q;

endmodule
